cam_init_seq: RTL and testbench
===============================

# cam_init_seq

Camera power-up and register-initialisation sequencer. It sits between the camera top level and the SCCB write engine. After a start pulse it:
- pulses the camera hardware reset;
- waits for sensor settle;
- walks a register table in a synchronous ROM, issuing one SCCB write per entry through a valid/ack handshake;
- retries NACKed writes, then reports done or error.

## Interface
- RST_LOW_CYC, 1000: cycles cam_rst is driven low per sequence
- RST_WAIT_CYC, 100000: cycles after cam_rst release before the first write
- GAP_CYC, 1000: idle cycles between completed writes
- NUM_REGS, 64: table depth; ROM address width AW = $clog2(NUM_REGS)
- MAX_RETRY, 3: extra attempts per entry after a NACK
- SLAVE_ID, 8'h42: SCCB write ID presented on wr_id

- clk  input  1  system clock, the same clock as the SCCB engine
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; honoured only in IDLE, DONE or ERROR
- cam_rst  output  1  camera hardware reset, active-low
- rom_addr  output  AW  table index
- rom_data  input  16  entry {reg_addr[15:8], reg_data[7:0]}; valid 1 cycle after rom_addr changes
- wr_req  output  1  write request (valid)
- wr_id  output  8  constant SLAVE_ID
- wr_addr  output  8  register address
- wr_data  output  8  register data
- wr_ack  input  1  engine accepts the request in the cycle wr_req && wr_ack
- wr_done  input  1  one-cycle pulse when the write transaction ends
- wr_nack  input  1  qualified by wr_done; 1 = slave NACKed
- busy  output  1  high in every state except IDLE, DONE, ERROR
- init_done  output  1  high in DONE
- init_err  output  1  high in ERROR
- err_index  output  AW  index of the failing entry; valid while init_err

## Operation
- States and transitions:
  - IDLE: on start → RST_LOW.
  - RST_LOW: drive cam_rst=0 for RST_LOW_CYC cycles → RST_WAIT.
  - RST_WAIT: cam_rst=1 for RST_WAIT_CYC cycles; set index=0 → FETCH.
  - FETCH: present rom_addr=index; wait 1 cycle → CHECK.
  - CHECK: rom_data==16'hFFFF (end marker) → DONE; otherwise latch wr_addr/wr_data, clear the retry count → ISSUE.
  - ISSUE: hold wr_req=1 until wr_ack → WAIT_DONE.
  - WAIT_DONE: on wr_done:
    - wr_nack=0 → GAP.
    - wr_nack=1 and retry<MAX_RETRY → increment retry, → ISSUE (same entry).
    - wr_nack=1 and retry==MAX_RETRY → err_index=index, → ERROR.
  - GAP: count GAP_CYC cycles. If index==NUM_REGS-1 → DONE; otherwise index+1 → FETCH.
  - DONE, ERROR: hold; start → RST_LOW, which clears init_done, init_err and err_index.
- The ROM is walked without a hard-coded length. An end marker at index 0 goes straight to DONE after RST_WAIT, with no writes.
- cam_rst is 0 from reset through IDLE and RST_LOW. It is 1 from RST_WAIT onward, including DONE and ERROR.
- start is ignored while busy.
- wr_done arriving outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - cam_rst=0, wr_req=0, busy=0, init_done=0, init_err=0.
  - rom_addr=0, wr_addr=0, wr_data=0, err_index=0.
  - FSM=IDLE; all counters 0.
- Reset asserted mid-sequence aborts immediately:
  - wr_req drops asynchronously.
  - The engine must tolerate an abandoned request; it shares the same reset.
- All outputs are registered.
- wr_req rises the cycle after CHECK.
- wr_addr and wr_data are stable from the first cycle of wr_req until wr_done.
- wr_req falls the cycle after the ack cycle; it is never high in WAIT_DONE.
- Cycle counts:
  - cam_rst low lasts exactly RST_LOW_CYC cycles.
  - From the first cam_rst=1 cycle to the first wr_req=1 is RST_WAIT_CYC+2 cycles (FETCH, CHECK).
  - From wr_done (ACK) to the next wr_req is GAP_CYC+2 cycles.
- Delay counter width: $clog2(max(RST_LOW_CYC, RST_WAIT_CYC, GAP_CYC)+1). Each delay counts down from its value minus 1 to 0; no wrap.
- Retry counter width: $clog2(MAX_RETRY+1).
- The index never wraps past NUM_REGS-1.

## Structure
- Shared package cam_pkg holds:
  - the state enum;
  - END_MARKER = 16'hFFFF;
  - the default SLAVE_ID;
  - the entry field slices (ENTRY_ADDR, ENTRY_DATA).
- One natural sub-module: cam_delay_cnt, a loadable down-counter with a zero flag, shared by RST_LOW, RST_WAIT and GAP.
- The ROM lives outside this block, so table content can change without touching this block.

## Test plan
- Nominal table, with parameters shrunk to RST_LOW_CYC=4, RST_WAIT_CYC=8, GAP_CYC=2:
  - Stimulus: ROM {1280, 1101, FFFF}; engine acks 1 cycle after req, done 10 cycles later.
  - Required: cam_rst low for 4 cycles; writes (12,80) then (11,01) with id 42; init_done high; busy low.
- Single NACK:
  - Stimulus: first write NACKed once, then ACKed.
  - Required: the same (addr,data) is reissued once, the sequence continues, and it ends with init_done=1.
- Persistent NACK:
  - Stimulus: entry index 1 NACKed 4 times.
  - Required: exactly 4 attempts on index 1; init_err=1; err_index=1; no further wr_req.
- Empty table and full table:
  - ROM[0]=FFFF → DONE with zero wr_req.
  - NUM_REGS=4 with no marker → exactly 4 writes, then DONE.
- Start ignored while busy:
  - Stimulus: start pulsed during WAIT_DONE.
  - Required: no effect on the sequence.
- Reset mid-write, then restart:
  - Stimulus: reset asserted during ISSUE.
  - Required: all outputs take their reset values at once.
  - Stimulus: start after reset released.
  - Required: the sequence restarts at RST_LOW with index 0.

Source files
------------

// File: rtl/cam_init_seq_pkg.sv
// Shared types and constants for the camera init sequencer: FSM states,
// table entry layout and the end-of-table marker.
package cam_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } cam_state_e;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [7:0]  DEF_SLAVE_ID = 8'h42;

  // Table entry is {reg_addr, reg_data}; these are the field offsets.
  localparam int ENTRY_W    = 8;
  localparam int ENTRY_ADDR = 8;
  localparam int ENTRY_DATA = 0;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cam_init_seq_delay_cnt.sv
// Loadable down-counter with zero flag; shared by the reset-low, reset-wait
// and inter-write gap delays. Saturates at zero.
module cam_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cam_init_seq.sv
// Camera power-up sequencer: pulses cam_rst, waits for settle, then walks an
// external register ROM issuing one SCCB write per entry, with NACK retries.
module cam_init_seq
  import cam_pkg::*;
#(
  parameter int          RST_LOW_CYC  = 1000,
  parameter int          RST_WAIT_CYC = 100000,
  parameter int          GAP_CYC      = 1000,
  parameter int          NUM_REGS     = 64,
  parameter int          MAX_RETRY    = 3,
  parameter logic [7:0]  SLAVE_ID     = DEF_SLAVE_ID,
  localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          cam_rst,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          wr_req,
  output logic [7:0]    wr_id,
  output logic [7:0]    wr_addr,
  output logic [7:0]    wr_data,
  input  logic          wr_ack,
  input  logic          wr_done,
  input  logic          wr_nack,
  output logic          busy,
  output logic          init_done,
  output logic          init_err,
  output logic [AW-1:0] err_index
);

  localparam int DMAX = max3(RST_LOW_CYC, RST_WAIT_CYC, GAP_CYC) + 1;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cam_state_e    state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [AW-1:0] err_index_q, err_index_d;
  logic          cam_rst_q, wr_req_q, busy_q, init_done_q, init_err_q;

  logic          cnt_load;
  logic [DW-1:0] cnt_val;
  logic          cnt_zero;

  cam_delay_cnt #(.W(DW)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    retry_d     = retry_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_index_d = err_index_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_RST_LOW;
          index_d     = '0;
          err_index_d = '0;
          cnt_load    = 1'b1;
          cnt_val     = DW'(RST_LOW_CYC - 1);
        end
      end
      S_RST_LOW: begin
        if (cnt_zero) begin
          state_d  = S_RST_WAIT;
          cnt_load = 1'b1;
          cnt_val  = DW'(RST_WAIT_CYC - 1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_zero) begin
          state_d = S_FETCH;
          index_d = '0;
        end
      end
      // rom_addr already shows index; synchronous ROM answers next cycle
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (rom_data == END_MARKER) begin
          state_d = S_DONE;
        end else begin
          wr_addr_d = rom_data[ENTRY_ADDR +: ENTRY_W];
          wr_data_d = rom_data[ENTRY_DATA +: ENTRY_W];
          retry_d   = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_ack) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wr_done) begin
          if (!wr_nack) begin
            state_d  = S_GAP;
            cnt_load = 1'b1;
            cnt_val  = DW'(GAP_CYC - 1);
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            err_index_d = index_q;
            state_d     = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          if (index_q == AW'(NUM_REGS - 1)) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      retry_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_index_q <= '0;
      cam_rst_q   <= 1'b0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_index_q <= err_index_d;
      cam_rst_q   <= !(state_d inside {S_IDLE, S_RST_LOW});
      wr_req_q    <= (state_d == S_ISSUE);
      busy_q      <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
      init_done_q <= (state_d == S_DONE);
      init_err_q  <= (state_d == S_ERROR);
    end
  end

  assign cam_rst   = cam_rst_q;
  assign rom_addr  = index_q;
  assign wr_req    = wr_req_q;
  assign wr_id     = SLAVE_ID;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign init_err  = init_err_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Bench for cam_init_seq: directed and random ROM/NACK scenarios checked
// against a table-walk reference model of the expected write attempts.
module tb_cam_init_seq;

  localparam int         RST_LOW_CYC  = 4;
  localparam int         RST_WAIT_CYC = 8;
  localparam int         GAP_CYC      = 2;
  localparam int         NUM_REGS     = 4;
  localparam int         MAX_RETRY    = 3;
  localparam logic [7:0] SLAVE_ID     = 8'h42;
  localparam int         DONE_LAT     = 10;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       cam_rst, wr_req, busy, init_done, init_err;
  logic [1:0] rom_addr, err_index;
  logic [15:0] rom_data;
  logic [7:0] wr_id, wr_addr, wr_data;
  logic       wr_ack, wr_done, wr_nack;

  always #5 clk = ~clk;

  cam_init_seq #(
    .RST_LOW_CYC(RST_LOW_CYC), .RST_WAIT_CYC(RST_WAIT_CYC), .GAP_CYC(GAP_CYC),
    .NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY), .SLAVE_ID(SLAVE_ID)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cam_rst(cam_rst),
    .rom_addr(rom_addr), .rom_data(rom_data), .wr_req(wr_req), .wr_id(wr_id),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
    .wr_nack(wr_nack), .busy(busy), .init_done(init_done), .init_err(init_err),
    .err_index(err_index)
  );

  // Synchronous ROM
  logic [15:0] rom [NUM_REGS];
  int          nack_plan [NUM_REGS];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB engine model: ack one cycle after req, done DONE_LAT cycles later.
  int used [NUM_REGS];
  initial begin : engine
    int  pend;
    bit  pnack;
    wr_ack = 0; wr_done = 0; wr_nack = 0; pend = 0; pnack = 0;
    forever begin
      @(posedge clk); #1;
      wr_done = 0; wr_nack = 0;
      if (!busy) for (int i = 0; i < NUM_REGS; i++) used[i] = 0;
      if (!reset) begin
        wr_ack = 0; pend = 0;
      end else if (wr_ack) begin
        wr_ack = 0;
        pend   = DONE_LAT;
        pnack  = (used[rom_addr] < nack_plan[rom_addr]);
        used[rom_addr]++;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin wr_done = 1; wr_nack = pnack; end
      end else if (wr_req) begin
        wr_ack = 1;
      end
    end
  end

  // Observation monitor
  logic        mon_clr;
  logic [23:0] acc_q [$];
  int cyc, rise, rstlo, first_hi, first_req, done_cyc, gap, id_bad, unstable;
  initial begin : monitor
    logic req_prev;
    req_prev = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clr) begin
        acc_q.delete();
        rise = 0; rstlo = 0; first_hi = -1; first_req = -1;
        done_cyc = -1; gap = -1; id_bad = 0; unstable = 0;
      end else begin
        if (wr_req && !req_prev) begin
          rise++;
          if (first_req < 0) first_req = cyc;
          if (done_cyc >= 0 && gap < 0) gap = cyc - done_cyc;
        end
        if (busy && !cam_rst) rstlo++;
        if (busy && cam_rst && first_hi < 0) first_hi = cyc;
        if (wr_req && wr_ack) begin
          acc_q.push_back({6'd0, rom_addr, wr_addr, wr_data});
          if (wr_id !== SLAVE_ID) id_bad++;
        end
        if (wr_done && acc_q.size() > 0 && {wr_addr, wr_data} !== acc_q[$][15:0]) unstable++;
        if (wr_done && !wr_nack && done_cyc < 0) done_cyc = cyc;
      end
      req_prev = wr_req;
    end
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the table, each entry gets nacks+1 attempts, capped
  // at MAX_RETRY+1 after which the walk stops with an error on that entry.
  logic [23:0] exp_q [$];
  bit          exp_err;
  int          exp_eidx;
  bit          exp_gap;
  task automatic model();
    int att;
    exp_q.delete(); exp_err = 0; exp_eidx = 0; exp_gap = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rom[i] == 16'hFFFF) break;
      if (i == 1) exp_gap = 1;
      att = (nack_plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : nack_plan[i] + 1;
      repeat (att) exp_q.push_back({8'(i), rom[i]});
      if (nack_plan[i] > MAX_RETRY) begin exp_err = 1; exp_eidx = i; break; end
    end
  endtask

  task automatic clr_mon();
    @(posedge clk); #1 mon_clr = 1;
    @(negedge clk); #1 mon_clr = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic run_seq(input bit poke);
    bit ended, poked;
    model();
    clr_mon();
    pulse_start();
    ended = 0; poked = 0;
    for (int i = 0; i < 3000 && !ended; i++) begin
      @(posedge clk); #1;
      start = 0;
      if (poke && !poked && acc_q.size() == 1) begin start = 1; poked = 1; end
      ended = (init_done || init_err);
    end
    start = 0;
    chk("seq_ended", 32'(ended), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("attempts", acc_q.size(), exp_q.size());
    chk("req_rises", rise, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk($sformatf("write%0d", i), acc_q[i], exp_q[i]);
    chk("init_done", 32'(init_done), 32'(!exp_err));
    chk("init_err", 32'(init_err), 32'(exp_err));
    chk("err_index", 32'(err_index), exp_err ? exp_eidx : 0);
    chk("busy_end", 32'(busy), 0);
    chk("cam_rst_end", 32'(cam_rst), 1);
    chk("rst_low_cycles", rstlo, RST_LOW_CYC);
    chk("wr_id_bad", id_bad, 0);
    chk("addr_data_unstable", unstable, 0);
    if (exp_q.size() > 0) chk("rst_to_first_req", first_req - first_hi, RST_WAIT_CYC + 2);
    // cycles strictly between the acked wr_done and the next wr_req
    if (exp_gap) chk("gap_cycles", gap - 1, GAP_CYC + 2);
  endtask

  task automatic set_rom(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    for (int i = 0; i < NUM_REGS; i++) nack_plan[i] = 0;
  endtask

  initial begin : main
    reset = 0; start = 0; mon_clr = 0;
    set_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cam_rst", 32'(cam_rst), 0);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_init_err", 32'(init_err), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_err_index", 32'(err_index), 0);
    chk("wr_id", 32'(wr_id), 32'h42);
    reset = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_cam_rst", 32'(cam_rst), 0);
    chk("idle_busy", 32'(busy), 0);

    // Nominal table
    set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    run_seq(0);
    chk("nom_w0", acc_q[0], 24'h00_1280);
    chk("nom_w1", acc_q[1], 24'h01_1101);

    // Single NACK on first entry
    set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    nack_plan[0] = 1;
    run_seq(0);
    chk("single_nack_attempts", acc_q.size(), 3);

    // Persistent NACK on index 1
    set_rom(16'h1280, 16'h1101, 16'h3344, 16'hFFFF);
    nack_plan[1] = 4;
    run_seq(0);
    chk("persist_err_index", 32'(err_index), 1);
    chk("persist_attempts", acc_q.size(), 5);

    // Empty table
    set_rom(16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC);
    run_seq(0);
    chk("empty_no_req", rise, 0);

    // Full table, no marker
    set_rom(16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04);
    run_seq(0);
    chk("full_writes", acc_q.size(), 4);

    // Start pulsed during WAIT_DONE
    set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    run_seq(1);

    // Random tables and NACK patterns
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
        nack_plan[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0;
      end
      run_seq(0);
    end

    // Reset mid-write, then restart
    set_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    clr_mon();
    pulse_start();
    for (int i = 0; i < 200 && !wr_req; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_req_seen", 32'(wr_req), 1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("midrst_wr_req", 32'(wr_req), 0);
    chk("midrst_cam_rst", 32'(cam_rst), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_wr_addr", 32'(wr_addr), 0);
    chk("midrst_wr_data", 32'(wr_data), 0);
    chk("midrst_init_done", 32'(init_done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    run_seq(0);
    chk("restart_w0", acc_q[0], 24'h00_1280);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
